data_ram_burst: RTL and testbench

Parametrised slow data memory model for the cache/memory-hierarchy experiments. It replaces the fixed-width, single-delay data RAM with:
- configurable data width and depth;
- separate read and write latencies;
- byte-enable writes;
- wrapping (critical-word-first) burst transfers for cache line fill and writeback.

It sits behind the data cache / MEM stage and signals progress with stall/ack/last.

---
 rtl/data_ram_burst.sv | 161 ++++++++++++++++
 tb/tb_data_ram_burst.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_burst.sv
// Slow data memory model with separate read/write latencies, byte-enable
// writes and wrapping (critical-word-first) bursts for cache line transfers.
//
// Handshake: the master raises cs with we/burst/addr and holds cs high for
// the whole transaction. Each completed beat produces a one-cycle ack
// (registered); the final beat also raises last. stall = cs & ~(ack & last).
// Write data for beat 0 must be valid with the request; data for beat k+1 is
// sampled at the edge closing the cycle in which beat k's ack is high.
// Dropping cs aborts the transaction at the next edge.
module data_ram_burst #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int READ_DELAY  = 8,
  parameter int WRITE_DELAY = 4,
  parameter int BURST_LEN   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cs,
  input  logic                    we,
  input  logic                    burst,
  input  logic [31:0]             addr,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    stall,
  output logic                    ack,
  output logic                    last
);

  localparam int NB        = DATA_WIDTH / 8;
  localparam int B         = $clog2(NB);
  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int MAX_DELAY = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
  localparam int CW        = (MAX_DELAY > 2) ? $clog2(MAX_DELAY) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } state_t;

  // FSM state is kept as a named signal so checkers can bind to it
  state_t                  state;
  logic [ADDR_WIDTH-1:0]   lat_idx;
  logic                    lat_we;
  logic                    lat_burst;
  logic [CW-1:0]           dly_cnt;
  logic [ADDR_WIDTH-1:0]   beat_cnt;

  // Storage holds (value XOR word index), so an all-zero power-up image
  // reads back as word i = i without any initialisation logic.
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   req_idx;
  logic [ADDR_WIDTH-1:0]   line_mask;
  logic [ADDR_WIDTH-1:0]   beat_idx;
  logic [DATA_WIDTH-1:0]   idx_word;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [CW-1:0]           delay_target;
  logic                    req_changed;
  logic                    wait_done;
  logic                    do_beat;
  logic                    unused_addr_bits;

  assign req_idx          = addr[ADDR_WIDTH+B-1:B];
  assign unused_addr_bits = ^addr;
  assign line_mask        = ADDR_WIDTH'(BURST_LEN - 1);

  // Wrap inside the aligned line: keep the line base, advance the offset
  assign beat_idx = (lat_idx & ~line_mask) | ((lat_idx + beat_cnt) & line_mask);
  assign idx_word = DATA_WIDTH'(beat_idx);
  assign rd_word  = mem[beat_idx] ^ idx_word;

  // Beat 0 happens on the edge where the counter reaches D-2 (ack in cycle D)
  assign delay_target = lat_we ? CW'(WRITE_DELAY - 2) : CW'(READ_DELAY - 2);
  assign req_changed  = (req_idx != lat_idx) || (we != lat_we) || (burst != lat_burst);
  assign wait_done    = (state == S_WAIT) && !req_changed && (dly_cnt == delay_target);
  assign do_beat      = cs && !rst && (wait_done || (state == S_BURST));

  assign stall = cs & ~(ack & last);

  // Byte-enabled write of the current beat; contents survive reset
  always_ff @(posedge clk) begin
    if (do_beat && lat_we) begin
      for (int j = 0; j < NB; j++) begin
        if (be[j]) mem[beat_idx][8*j +: 8] <= din[8*j +: 8] ^ idx_word[8*j +: 8];
      end
    end
  end

  // Control FSM: request latch, latency count, beat sequencing, ack/last/dout
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      lat_idx   <= '0;
      lat_we    <= 1'b0;
      lat_burst <= 1'b0;
      dly_cnt   <= '0;
      beat_cnt  <= '0;
      ack       <= 1'b0;
      last      <= 1'b0;
      dout      <= '0;
    end else begin
      ack  <= 1'b0;
      last <= 1'b0;
      dout <= '0;
      if (!cs) begin
        state    <= S_IDLE;
        dly_cnt  <= '0;
        beat_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            lat_idx   <= req_idx;
            lat_we    <= we;
            lat_burst <= burst;
            dly_cnt   <= '0;
            beat_cnt  <= '0;
            state     <= S_WAIT;
          end
          S_WAIT: begin
            if (req_changed) begin
              lat_idx   <= req_idx;
              lat_we    <= we;
              lat_burst <= burst;
              dly_cnt   <= '0;
            end else if (wait_done) begin
              ack     <= 1'b1;
              dout    <= lat_we ? '0 : rd_word;
              dly_cnt <= '0;
              if (!lat_burst || BURST_LEN == 1) begin
                last     <= 1'b1;
                beat_cnt <= '0;
                state    <= S_IDLE;
              end else begin
                beat_cnt <= ADDR_WIDTH'(1);
                state    <= S_BURST;
              end
            end else begin
              dly_cnt <= dly_cnt + 1'b1;
            end
          end
          S_BURST: begin
            ack  <= 1'b1;
            dout <= lat_we ? '0 : rd_word;
            if (beat_cnt == ADDR_WIDTH'(BURST_LEN - 1)) begin
              last     <= 1'b1;
              beat_cnt <= '0;
              state    <= S_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_ram_burst.sv
// Bench for data_ram_burst with default parameters (32-bit words, depth 32,
// read delay 8, write delay 4, 4-beat bursts).
module tb_data_ram_burst;

  logic        clk;
  logic        rst;
  logic        cs;
  logic        we;
  logic        burst;
  logic [31:0] addr;
  logic [31:0] din;
  logic [3:0]  be;
  logic [31:0] dout;
  logic        stall;
  logic        ack;
  logic        last;

  int checks = 0;
  int errors = 0;

  data_ram_burst dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .burst(burst), .addr(addr),
    .din(din), .be(be), .dout(dout), .stall(stall), .ack(ack), .last(last)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference memory image, word-level
  logic [31:0] model [32];

  // per-transaction stimulus and expectations
  logic [31:0] wd  [4];
  logic [3:0]  wbe [4];
  logic [31:0] ed  [4];
  int          efirst;

  typedef struct {
    logic        t_we;
    logic        t_burst;
    logic [31:0] t_addr;
    logic [31:0] d [4];
    logic [3:0]  b;
    int          first;
    logic [31:0] e [4];
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int beat_index(input logic [31:0] a, input int k);
    int idx;
    idx = int'((a >> 2) % 32);
    return (idx / 4) * 4 + ((idx % 4) + k) % 4;
  endfunction

  task automatic model_write(input logic [31:0] a, input int k, input logic [31:0] d,
                             input logic [3:0] b);
    int idx;
    idx = beat_index(a, k);
    for (int j = 0; j < 4; j++) if (b[j]) model[idx][8*j +: 8] = d[8*j +: 8];
  endtask

  task automatic exp_from_model(input logic [31:0] a);
    for (int k = 0; k < 4; k++) ed[k] = model[beat_index(a, k)];
  endtask

  task automatic idle(input int n);
    cs = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      chk("idle_ack", ack, 0);
      chk("idle_stall", stall, 0);
    end
  endtask

  // driver: starts in the current cycle (cycle 0), feeds write data per ack,
  // returns in the last-ack cycle with cs still high
  task automatic run_txn(input logic t_we, input logic t_burst, input logic [31:0] t_addr);
    int nb, nack, cyc;
    nb = t_burst ? 4 : 1;
    cs = 1'b1; we = t_we; burst = t_burst; addr = t_addr;
    din = wd[0]; be = wbe[0];
    nack = 0; cyc = 0;
    while (nack < nb && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (ack) begin
        chk("ack_cycle", cyc, efirst + nack);
        chk("dout", dout, t_we ? 32'd0 : ed[nack]);
        chk("last", last, 64'(nack == nb - 1));
        if (t_we) model_write(t_addr, nack, wd[nack], wbe[nack]);
        nack++;
        if (nack < nb) begin
          din = wd[nack]; be = wbe[nack];
        end
      end else begin
        chk("dout_no_ack", dout, 0);
        chk("last_no_ack", last, 0);
      end
      chk("stall", stall, 64'(!(ack && nack == nb)));
    end
    if (nack < nb) chk("txn_timeout_beats", nack, nb);
  endtask

  initial begin
    int nack, cyc;
    logic got;
    for (int i = 0; i < 32; i++) model[i] = i;
    rst = 1'b1; cs = 1'b0; we = 1'b0; burst = 1'b0; addr = '0; din = '0; be = '0;
    for (int k = 0; k < 4; k++) begin wd[k] = '0; wbe[k] = '0; ed[k] = '0; end
    efirst = 8;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ack", ack, 0);
    chk("rst_last", last, 0);
    chk("rst_dout", dout, 0);
    chk("rst_stall", stall, 0);

    // directed vector table
    vt[0] = '{t_we:1'b0, t_burst:1'b0, t_addr:32'h14, d:'{0,0,0,0}, b:4'h0, first:8,
              e:'{32'h5, 0, 0, 0}};
    vt[1] = '{t_we:1'b1, t_burst:1'b0, t_addr:32'h08, d:'{32'hAABBCCDD, 0, 0, 0}, b:4'b0011,
              first:4, e:'{0, 0, 0, 0}};
    vt[2] = '{t_we:1'b0, t_burst:1'b0, t_addr:32'h08, d:'{0,0,0,0}, b:4'h0, first:8,
              e:'{32'h0000CCDD, 0, 0, 0}};
    vt[3] = '{t_we:1'b0, t_burst:1'b1, t_addr:32'h1C, d:'{0,0,0,0}, b:4'h0, first:8,
              e:'{32'd7, 32'd4, 32'd5, 32'd6}};
    vt[4] = '{t_we:1'b1, t_burst:1'b1, t_addr:32'h20, d:'{32'h100, 32'h101, 32'h102, 32'h103},
              b:4'hF, first:4, e:'{0, 0, 0, 0}};
    vt[5] = '{t_we:1'b0, t_burst:1'b1, t_addr:32'h20, d:'{0,0,0,0}, b:4'h0, first:8,
              e:'{32'h100, 32'h101, 32'h102, 32'h103}};
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 4; k++) begin
        wd[k] = vt[v].d[k]; wbe[k] = vt[v].b; ed[k] = vt[v].e[k];
      end
      efirst = vt[v].first;
      run_txn(vt[v].t_we, vt[v].t_burst, vt[v].t_addr);
      idle(2);
    end

    // request address changes while waiting: latency restarts
    cs = 1'b1; we = 1'b0; burst = 1'b0; addr = 32'h04;
    got = 1'b0;
    for (cyc = 1; cyc <= 20 && !got; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 3) addr = 32'h0C;
      if (ack) begin
        chk("chg_ack_cycle", cyc, 11);
        chk("chg_dout", dout, model[3]);
        chk("chg_last", last, 1);
        got = 1'b1;
      end
    end
    if (!got) chk("chg_timeout", 0, 1);
    idle(2);

    // burst read aborted by dropping cs after the second ack
    exp_from_model(32'h10);
    cs = 1'b1; we = 1'b0; burst = 1'b1; addr = 32'h10;
    nack = 0;
    for (cyc = 1; cyc <= 20 && nack < 2; cyc++) begin
      @(posedge clk); #1;
      if (ack) begin
        chk("abort_dout", dout, ed[nack]);
        nack++;
      end
    end
    chk("abort_acks_seen", nack, 2);
    cs = 1'b0;
    #1;
    chk("abort_stall_now", stall, 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_ack", ack, 0);
      chk("abort_stall", stall, 0);
    end
    exp_from_model(32'h0);
    efirst = 8;
    run_txn(1'b0, 1'b0, 32'h0);
    idle(2);

    // reset in the middle of a burst write
    for (int k = 0; k < 4; k++) begin wd[k] = 32'h5550 + k; wbe[k] = 4'hF; end
    cs = 1'b1; we = 1'b1; burst = 1'b1; addr = 32'h30; din = wd[0]; be = wbe[0];
    nack = 0;
    for (cyc = 1; cyc <= 20 && nack < 2; cyc++) begin
      @(posedge clk); #1;
      if (ack) begin
        model_write(32'h30, nack, wd[nack], wbe[nack]);
        nack++;
        din = wd[nack];
      end
    end
    chk("rstw_acks_seen", nack, 2);
    rst = 1'b1; cs = 1'b0;
    @(posedge clk); #1;
    chk("rstw_ack", ack, 0);
    chk("rstw_last", last, 0);
    chk("rstw_dout", dout, 0);
    rst = 1'b0;
    idle(2);
    exp_from_model(32'h30);
    efirst = 8;
    run_txn(1'b0, 1'b1, 32'h30);
    idle(1);

    // randomized traffic, including back-to-back and full-width addresses
    for (int t = 0; t < 40; t++) begin
      logic r_we, r_burst;
      logic [31:0] r_addr;
      r_we    = 1'($urandom_range(0, 1));
      r_burst = 1'($urandom_range(0, 1));
      r_addr  = $urandom();
      for (int k = 0; k < 4; k++) begin
        wd[k]  = $urandom();
        wbe[k] = 4'($urandom_range(0, 15));
      end
      exp_from_model(r_addr);
      efirst = r_we ? 4 : 8;
      run_txn(r_we, r_burst, r_addr);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
    end
    idle(1);

    // final sweep: read back every line
    for (int l = 0; l < 8; l++) begin
      exp_from_model(32'(l * 16));
      efirst = 8;
      run_txn(1'b0, 1'b1, 32'(l * 16));
    end
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
